uart_rx_8n1: RTL and testbench



---
 rtl/tt_uart_pkg.sv | 21 ++
 rtl/sync_ff.sv | 29 ++
 rtl/uart_rx_8n1.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_uart_pkg.sv
`default_nettype none
// ============================================================================
// tt_uart_pkg : shared types and constants for the tiny UART receive path
// Revision    : 1.0
// ============================================================================
package tt_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

endpackage : tt_uart_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// sync_ff  : multi-stage synchroniser for an asynchronous single-bit input
// Revision : 1.0
// ============================================================================
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// uart_rx_8n1 : 8N1 serial receiver (8N1 + even parity with UART_RX_PARITY_EN)
// Revision    : 1.0
// ============================================================================
module uart_rx_8n1
  import tt_uart_pkg::*;
#(
  parameter int CLK_DIV     = 104,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int                CNT_W        = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] C_BIT_RELOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF_RELOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       C_LAST_IDX    = 3'(DATA_BITS - 1);

  logic                   w_rx_s;
  rx_state_e              r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic [2:0]             r_idx, w_idx;
  logic [DATA_BITS-1:0]   r_shift, w_shift;
  logic [DATA_BITS-1:0]   r_data, w_data;
  logic                   r_valid, w_valid;
  logic                   r_frame_err, w_frame_err;
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_armed;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par;
  logic                   r_parity_err, w_parity_err;
`endif

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  // Start edges are only honoured once the real line has been seen idle after
  // reset; the synchroniser's reset value must flush out before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_armed  <= r_armed | (r_settle[SYNC_STAGES-1] & (w_rx_s == IDLE_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_shift     <= w_shift;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_frame_err <= w_frame_err;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par        <= w_par;
      r_parity_err <= w_parity_err;
    end
  end
`endif

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_shift     = r_shift;
    w_data      = r_data;
    w_valid     = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par        = r_par;
    w_parity_err = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (r_armed && (w_rx_s != IDLE_LEVEL)) begin
          w_state = START;
          w_cnt   = C_HALF_RELOAD;
        end
      end
      START: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (w_rx_s == IDLE_LEVEL) begin
          w_state = IDLE;
        end else begin
          w_state = DATA;
          w_idx   = '0;
          w_cnt   = C_BIT_RELOAD;
        end
      end
      DATA: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_shift = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_cnt   = C_BIT_RELOAD;
          if (r_idx == C_LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_par   = w_rx_s;
          w_cnt   = C_BIT_RELOAD;
          w_state = STOP;
        end
      end
`endif
      STOP: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (w_rx_s == IDLE_LEVEL) begin
          // Returning to IDLE mid-stop-bit lets back-to-back frames through.
          w_state = IDLE;
`ifdef UART_RX_PARITY_EN
          if ((^r_shift) ^ r_par) begin
            w_parity_err = 1'b1;
          end else begin
            w_data  = r_shift;
            w_valid = 1'b1;
          end
`else
          w_data  = r_shift;
          w_valid = 1'b1;
`endif
        end else begin
          w_frame_err = 1'b1;
          w_state     = BREAK;
        end
      end
      BREAK: begin
        if (w_rx_s == IDLE_LEVEL) begin
          w_state = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule : uart_rx_8n1
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_8n1 : directed self-checking bench for uart_rx_8n1 (CLK_DIV=16)
// Revision       : 1.0
// ============================================================================
module tb_uart_rx_8n1;

  localparam int CLK_DIV     = 16;
  localparam int SYNC_STAGES = 2;
  localparam int BIT_T       = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_8n1 #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  logic [7:0] rxq[$];
  logic       both_hi = 1'b0;
  logic       busy_after_valid = 1'b0;
  logic       prev_valid = 1'b0;
  int         busy_run = 0;
  int         busy_max = 0;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      rxq.push_back(data);
    end
    if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    if (valid && frame_err) both_hi = 1'b1;
    if (prev_valid && busy) busy_after_valid = 1'b1;
    prev_valid = valid;
    busy_run   = busy ? busy_run + 1 : 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  // rst_bit >= 0 pulses rst for one clock in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input int bit_t, input int stop_t,
                            input logic stop_lvl, input int rst_bit);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        #(bit_t / 2);
        rst = 1'b1;
        #10;
        rst = 1'b0;
        #(bit_t - bit_t / 2 - 10);
      end else begin
        #(bit_t);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    #(bit_t);
`endif
    rx = stop_lvl;
    #(stop_t);
    rx = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] b2b_bytes[3] = '{8'h00, 8'hFF, 8'h55};
  int         rates[3]     = '{BIT_T, BIT_T - 5, BIT_T + 5};

  initial begin
    int v0, f0;
    logic [31:0] got;

    idle_cycles(4);
    check_eq("reset_data", {24'h0, data}, 32'h00);
    check_eq("reset_valid", {31'h0, valid}, 32'h0);
    check_eq("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    idle_cycles(10);

    v0 = n_valid;
    send_frame(8'hA5, BIT_T, BIT_T, 1'b1, -1);
    idle_cycles(20);
    check_eq("a5_valid_count", n_valid - v0, 1);
    check_eq("a5_data", {24'h0, data}, 32'hA5);
    check_eq("a5_no_frame_err", n_ferr, 0);
    check_eq("a5_busy_idle", {31'h0, busy}, 32'h0);

    busy_max = 0;
    v0 = n_valid;
    rx = 1'b0;
    #50;
    rx = 1'b1;
    idle_cycles(40);
    check_eq("glitch_no_valid", n_valid - v0, 0);
    check_eq("glitch_no_frame_err", n_ferr, 0);
    check_eq("glitch_busy_idle", {31'h0, busy}, 32'h0);
    check_eq("glitch_busy_len_ok", {31'h0, (busy_max >= 1 && busy_max <= 9)}, 32'h1);

    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, BIT_T, 40 * 10, 1'b0, -1);
    idle_cycles(40);
    check_eq("brk_one_frame_err", n_ferr - f0, 1);
    check_eq("brk_no_valid", n_valid - v0, 0);
    check_eq("brk_data_kept", {24'h0, data}, 32'hA5);
    send_frame(8'h81, BIT_T, BIT_T, 1'b1, -1);
    idle_cycles(20);
    check_eq("after_brk_data", {24'h0, data}, 32'h81);
    check_eq("after_brk_valid_count", n_valid - v0, 1);
    check_eq("after_brk_no_new_ferr", n_ferr - f0, 1);

    for (int r = 0; r < 3; r++) begin
      rxq.delete();
      for (int k = 0; k < 3; k++) send_frame(b2b_bytes[k], rates[r], rates[r], 1'b1, -1);
      idle_cycles(40);
      check_eq($sformatf("b2b_r%0d_count", r), rxq.size(), 3);
      for (int k = 0; k < 3; k++) begin
        got = (k < rxq.size()) ? {24'h0, rxq[k]} : 32'hDEAD;
        check_eq($sformatf("b2b_r%0d_byte%0d", r, k), got, {24'h0, b2b_bytes[k]});
      end
    end

    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'hF0, BIT_T, BIT_T, 1'b1, 4);
    idle_cycles(40);
    check_eq("rst_mid_no_valid", n_valid - v0, 0);
    check_eq("rst_mid_no_ferr", n_ferr - f0, 0);
    check_eq("rst_mid_data_cleared", {24'h0, data}, 32'h00);
    send_frame(8'h12, BIT_T, BIT_T, 1'b1, -1);
    idle_cycles(20);
    check_eq("post_rst_data", {24'h0, data}, 32'h12);
    check_eq("post_rst_valid_count", n_valid - v0, 1);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid;
    f0 = n_perr;
    rx = 1'b0; #(BIT_T);
    for (int i = 0; i < 8; i++) begin rx = (i < 3); #(BIT_T); end
    rx = 1'b1; #(BIT_T);
    rx = 1'b1; #(BIT_T);
    idle_cycles(20);
    check_eq("par_good_valid", n_valid - v0, 1);
    check_eq("par_good_data", {24'h0, data}, 32'h07);
    rx = 1'b0; #(BIT_T);
    for (int i = 0; i < 8; i++) begin rx = (i < 3); #(BIT_T); end
    rx = 1'b0; #(BIT_T);
    rx = 1'b1; #(BIT_T);
    idle_cycles(20);
    check_eq("par_bad_no_valid", n_valid - v0, 1);
    check_eq("par_bad_perr", n_perr - f0, 1);
    check_eq("par_bad_data_kept", {24'h0, data}, 32'h07);
`endif

    check_eq("never_valid_and_ferr", {31'h0, both_hi}, 32'h0);
    check_eq("busy_low_after_valid", {31'h0, busy_after_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_8n1
`default_nettype wire
